// File: rtl/frame_ctrl_pkg.sv
// frame_ctrl_pkg: FSM state encoding and parameter legality checks shared by the frame ring writer
package frame_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ACK, S_CHECK, S_BURST, S_BURST_END, S_END} state_t;
  function automatic bit buf_num_ok(input int buf_num);
    return buf_num >= 2 && buf_num <= 8;
  endfunction
  function automatic bit idx_bits_ok(input int buf_num, input int idx_bits);
    return (1 << idx_bits) >= buf_num;
  endfunction
endpackage

// File: rtl/frame_ring_writer_if.sv
// frame_ring_writer_if: burst command/response bus between the frame writer and the memory controller
interface frame_ring_writer_if #(parameter int ADDR_BITS = 25, parameter int BURST_BITS = 10);
  logic                  wr_burst_req;
  logic [BURST_BITS-1:0] wr_burst_len;
  logic [ADDR_BITS-1:0]  wr_burst_addr;
  logic                  wr_burst_data_req;
  logic                  wr_burst_finish;
  modport master(output wr_burst_req, wr_burst_len, wr_burst_addr, input wr_burst_data_req, wr_burst_finish);
  modport slave(input wr_burst_req, wr_burst_len, wr_burst_addr, output wr_burst_data_req, wr_burst_finish);
endinterface

// File: rtl/sync_bit.sv
// sync_bit: three-flop synchroniser for a single asynchronous bit
module sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [2:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[1:0], d_i};
  assign q_o = sync_q[2];
endmodule

// File: rtl/frame_ring_writer.sv
// frame_ring_writer: writes frames from a source FIFO into a ring of buffers using controller bursts
module frame_ring_writer
  import frame_ctrl_pkg::*;
#(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 25,
  parameter int BURST_BITS    = 10,
  parameter int BURST_SIZE    = 64,
  parameter int BUF_NUM       = 3,
  parameter int IDX_BITS      = 3
) (
  input  logic                 mem_clk,
  input  logic                 rst_n,
  input  logic                 write_req,
  output logic                 write_req_ack,
  output logic                 write_finish,
  output logic                 frame_abort,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS-1:0] frame_stride,
  input  logic [ADDR_BITS-1:0] write_len,
  output logic                 fifo_aclr,
  input  logic [15:0]          rdusedw,
  frame_ring_writer_if.master  wr_bus,
  output logic [IDX_BITS-1:0]  wr_buf_idx,
  output logic [IDX_BITS-1:0]  done_buf_idx,
  output logic                 done_valid
);
  localparam logic [31:0] BS = 32'(BURST_SIZE);
  if (!buf_num_ok(BUF_NUM) || !idx_bits_ok(BUF_NUM, IDX_BITS) || BURST_SIZE < 1 ||
      BURST_SIZE >= (1 << BURST_BITS) || MEM_DATA_BITS < 1) begin : g_bad_cfg
    $error("frame_ring_writer: illegal parameter set");
  end
  state_t               state_q;
  logic                 req_s, enter_ack, wrap, burst_full, burst_tail;
  logic [ADDR_BITS-1:0] base_m_q, base_q, stride_m_q, stride_q, len_m_q, len_q;
  logic [ADDR_BITS-1:0] len_latch_q, write_cnt_q, ring_base_q, remaining, ring_d;
  logic [IDX_BITS-1:0]  idx_d;
  sync_bit u_req_sync (.clk(mem_clk), .rst_n(rst_n), .d_i(write_req), .q_o(req_s));
  always_ff @(posedge mem_clk or negedge rst_n)
    if (!rst_n) {base_m_q, base_q, stride_m_q, stride_q, len_m_q, len_q} <= '0;
    else {base_m_q, base_q, stride_m_q, stride_q, len_m_q, len_q} <=
      {base_addr, base_m_q, frame_stride, stride_m_q, write_len, len_m_q};
  // Ring base is accumulated buffer by buffer, restarting at base_addr on index wrap.
  always_comb begin
    remaining  = len_latch_q - write_cnt_q;
    wrap       = wr_buf_idx == IDX_BITS'(BUF_NUM - 1);
    idx_d      = wrap ? '0 : wr_buf_idx + IDX_BITS'(1);
    ring_d     = wrap ? base_q : ring_base_q + stride_q;
    burst_full = 32'(remaining) >= BS && 32'(rdusedw) >= BS;
    burst_tail = 32'(remaining) < BS && 32'(rdusedw) >= 32'(remaining);
    enter_ack  = req_s && (state_q == S_IDLE || state_q == S_CHECK || state_q == S_BURST_END);
  end
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= S_IDLE;
      write_req_ack        <= 1'b0;
      write_finish         <= 1'b0;
      frame_abort          <= 1'b0;
      fifo_aclr            <= 1'b0;
      wr_bus.wr_burst_req  <= 1'b0;
      wr_bus.wr_burst_len  <= '0;
      wr_bus.wr_burst_addr <= '0;
      wr_buf_idx           <= IDX_BITS'(BUF_NUM - 1);
      done_buf_idx         <= '0;
      done_valid           <= 1'b0;
      len_latch_q          <= '0;
      write_cnt_q          <= '0;
      ring_base_q          <= '0;
    end else begin
      write_finish <= 1'b0;
      frame_abort  <= 1'b0;
      // A request in IDLE, CHECK or BURST_END wins over every other transition.
      if (enter_ack) begin
        state_q       <= S_ACK;
        wr_buf_idx    <= idx_d;
        ring_base_q   <= ring_d;
        write_req_ack <= 1'b1;
        fifo_aclr     <= 1'b1;
        frame_abort   <= state_q != S_IDLE;
      end else
        case (state_q)
          S_IDLE: state_q <= S_IDLE;
          S_ACK: begin
            len_latch_q          <= len_q;
            write_cnt_q          <= '0;
            wr_bus.wr_burst_addr <= ring_base_q;
            write_req_ack        <= req_s;
            fifo_aclr            <= req_s;
            if (!req_s) state_q <= S_CHECK;
          end
          S_CHECK:
            if (remaining == '0) state_q <= S_END;
            else if (burst_full || burst_tail) begin
              wr_bus.wr_burst_len <= burst_full ? BURST_BITS'(BURST_SIZE) : BURST_BITS'(remaining);
              wr_bus.wr_burst_req <= 1'b1;
              state_q             <= S_BURST;
            end
          S_BURST:
            if (wr_bus.wr_burst_finish) begin
              wr_bus.wr_burst_req  <= 1'b0;
              write_cnt_q          <= write_cnt_q + ADDR_BITS'(wr_bus.wr_burst_len);
              wr_bus.wr_burst_addr <= wr_bus.wr_burst_addr + ADDR_BITS'(wr_bus.wr_burst_len);
              state_q              <= S_BURST_END;
            end
          S_BURST_END: state_q <= write_cnt_q < len_latch_q ? S_CHECK : S_END;
          S_END: begin
            write_finish <= 1'b1;
            done_buf_idx <= wr_buf_idx;
            done_valid   <= 1'b1;
            state_q      <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
    end
  end
endmodule
